syfifo_param: RTL and testbench
===============================

SYFIFO_PARAM -- requirements
Module: syfifo_param

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the data word width in bits (>=1).
REQ-002 The block SHALL take parameter DEPTH, default 16, as the number of entries (power of two, >=4).
REQ-003 The block SHALL take parameter AF_LEVEL, default DEPTH-2, as the almost_full threshold (1..DEPTH-1).
REQ-004 The block SHALL take parameter AE_LEVEL, default 2, as the almost_empty threshold (1..DEPTH-1).
REQ-005 The block SHALL take parameter FWFT, default 0, as the read mode (0 = registered read, 1 = first-word-fall-through).
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port flush, input, 1 bit: synchronous empty request.
REQ-009 Port wr_en, input, 1 bit: write request.
REQ-010 Port w_data, input, WIDTH bits: write data.
REQ-011 Port rd_en, input, 1 bit: read request.
REQ-012 Port r_data, output, WIDTH bits: read data.
REQ-013 Ports full, empty, almost_full, almost_empty, output, 1 bit each: registered status flags.
REQ-014 Port count, output, clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-015 Ports wr_err and rd_err, output, 1 bit each: one-cycle rejected-request pulses.

Function
REQ-016 Write and read pointers SHALL be clog2(DEPTH)+1 bits wide, the MSB acting as wrap bit; the address SHALL be the low clog2(DEPTH) bits, wrapping DEPTH-1 -> 0 with the MSB toggling.
REQ-017 A write SHALL be accepted when wr_en=1 and (full=0, or rd_en=1 with the read accepted in the same cycle); an accepted write stores w_data at the write address and advances the write pointer.
REQ-018 A read SHALL be accepted when rd_en=1 and empty=0; an accepted read advances the read pointer.
REQ-019 With wr_en=1 and rd_en=1 while empty=1, the write SHALL be accepted, the read rejected, and rd_err=1.
REQ-020 A rejected write SHALL raise wr_err for exactly one cycle and leave memory, pointers and count unchanged; a rejected read does likewise with rd_err.
REQ-021 count SHALL update each cycle by +1 (write only), -1 (read only) or 0 (both or neither).
REQ-022 All flags SHALL be registered from next-state count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-023 FWFT=0: r_data SHALL load the head word on the clock edge that accepts a read (valid the cycle after rd_en) and hold its value otherwise.
REQ-024 FWFT=1: r_data SHALL continuously present the word at the read address whenever empty=0; rd_en acknowledges and pops it; r_data is don't-care when empty=1.
REQ-025 flush=1 SHALL zero both pointers and count, set empty=1, almost_empty=1, full=0, almost_full=0, ignore wr_en/rd_en that cycle, raise no error pulse, and leave memory contents unchanged.

Reset
REQ-026 rst_n=0 SHALL asynchronously force pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, wr_err=0, rd_err=0, r_data=0; memory is not reset.
REQ-027 Operation SHALL resume on the first rising clk edge after rst_n deasserts; requests during reset are discarded.

Structure
REQ-028 A shared package syfifo_pkg SHALL hold the clog2 function and the FWFT mode constants.
REQ-029 Storage SHALL be a sub-module syfifo_ram (one write port, one asynchronous read port, no reset), instantiated once.

Verification
REQ-030 Fill: DEPTH=16, 16 writes of 0x01..0x10 -> count=16, full=1 on the cycle after the 16th write, almost_full=1 from count 14; 17th write -> wr_err=1, count stays 16.
REQ-031 Drain, FWFT=0: 16 reads -> r_data 0x01..0x10 one cycle after each rd_en, empty=1 after the last; extra read -> rd_err=1, r_data holds 0x10.
REQ-032 Simultaneous: full FIFO, wr_en=rd_en=1 with w_data=0xAA -> both accepted, count stays 16, 0xAA is read out last.
REQ-033 Empty simultaneous: empty FIFO, wr_en=rd_en=1 -> rd_err=1, count=1, empty=0.
REQ-034 FWFT=1: write 0x5C to empty FIFO -> r_data=0x5C the cycle after empty drops, before any rd_en.
REQ-035 Wrap and flush: 40 interleaved write/read pairs -> data order preserved across pointer wrap; flush at count=5 -> count=0, empty=1; asynchronous rst_n pulse mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/syfifo_pkg.sv
// rtl/syfifo_pkg.sv - shared sizing helper and read-mode constants for the syfifo family
package syfifo_pkg;

  localparam int FWFT_REG  = 0;
  localparam int FWFT_FALL = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/syfifo_ram.sv
// rtl/syfifo_ram.sv - unreset storage array, one synchronous write port, one asynchronous read port
module syfifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic [AW-1:0]    r_addr,
  output logic [WIDTH-1:0] r_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/syfifo_param.sv
// rtl/syfifo_param.sv - parameterised synchronous FIFO with registered flags and error pulses
module syfifo_param
  import syfifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FWFT_REG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        w_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        r_data,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [clog2(DEPTH):0]   count,
  output logic                    wr_err,
  output logic                    rd_err
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] ram_q, r_q;

  // A full FIFO may still take a write when the same-cycle read frees a slot.
  always_comb begin
    rd_acc     = rd_en && !empty && !flush;
    wr_acc     = wr_en && (!full || rd_acc) && !flush;
    wr_ptr_nxt = flush ? '0 : (wr_acc ? wr_ptr + ONE : wr_ptr);
    rd_ptr_nxt = flush ? '0 : (rd_acc ? rd_ptr + ONE : rd_ptr);
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  syfifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .we     (wr_acc),
    .w_addr (wr_ptr[AW-1:0]),
    .w_data (w_data),
    .r_addr (rd_ptr[AW-1:0]),
    .r_data (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      wr_err       <= 1'b0;
      rd_err       <= 1'b0;
      r_q          <= '0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      wr_err       <= wr_en && !wr_acc && !flush;
      rd_err       <= rd_en && !rd_acc && !flush;
      if (rd_acc) r_q <= ram_q;
    end
  end

  assign r_data = (FWFT == FWFT_FALL) ? (empty ? '0 : ram_q) : r_q;

endmodule

// File: tb/tb_syfifo_param.sv
// tb/tb_syfifo_param.sv - random and directed checks of syfifo_param (both read modes) against a queue model
module tb_syfifo_param;
  localparam int DEPTH = 16;

  logic       clk = 1'b0, rst_n = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic [7:0] r_data, r_data_f;
  logic       full, empty, almost_full, almost_empty, wr_err, rd_err;
  logic       full_f, empty_f, almost_full_f, almost_empty_f, wr_err_f, rd_err_f;
  logic [4:0] count, count_f;

  int         vectors = 0, miscompares = 0;
  logic [7:0] q[$];
  logic [7:0] m_rdata = 8'h00;
  logic       m_werr = 1'b0, m_rerr = 1'b0;

  always #5 clk = ~clk;

  syfifo_param #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .w_data(w_data), .rd_en(rd_en),
    .r_data(r_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .wr_err(wr_err), .rd_err(rd_err));

  syfifo_param #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .w_data(w_data), .rd_en(rd_en),
    .r_data(r_data_f), .full(full_f), .empty(empty_f), .almost_full(almost_full_f),
    .almost_empty(almost_empty_f), .count(count_f), .wr_err(wr_err_f), .rd_err(rd_err_f));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain queue of words plus the last word popped.
  task automatic model(input logic we, input logic re, input logic [7:0] d, input logic fl);
    logic rd_ok, wr_ok;
    if (fl) begin
      q.delete();
      m_werr = 1'b0;
      m_rerr = 1'b0;
    end else begin
      rd_ok  = re && (q.size() > 0);
      wr_ok  = we && ((q.size() < DEPTH) || rd_ok);
      m_werr = we && !wr_ok;
      m_rerr = re && !rd_ok;
      if (rd_ok) m_rdata = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
  endtask

  task automatic cycle(input logic we, input logic re, input logic [7:0] d, input logic fl);
    wr_en = we; rd_en = re; w_data = d; flush = fl;
    @(posedge clk);
    if (rst_n) model(we, re, d, fl);
    #1;
  endtask

  always @(negedge clk) begin : compare
    int n;
    if (rst_n) begin
      n = q.size();
      chk("count", count, n);
      chk("full", full, n == DEPTH);
      chk("empty", empty, n == 0);
      chk("almost_full", almost_full, n >= DEPTH - 2);
      chk("almost_empty", almost_empty, n <= 2);
      chk("wr_err", wr_err, m_werr);
      chk("rd_err", rd_err, m_rerr);
      chk("r_data", r_data, m_rdata);
      chk("count_f", count_f, n);
      chk("full_f", full_f, n == DEPTH);
      chk("empty_f", empty_f, n == 0);
      chk("almost_full_f", almost_full_f, n >= DEPTH - 2);
      chk("almost_empty_f", almost_empty_f, n <= 2);
      chk("wr_err_f", wr_err_f, m_werr);
      chk("rd_err_f", rd_err_f, m_rerr);
      if (n > 0) chk("r_data_f", r_data_f, q[0]);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_aempty"}, almost_empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_errs"}, {wr_err, rd_err}, 0);
    chk({tag, "_rdata"}, r_data, 0);
    chk({tag, "_rdata_f"}, r_data_f, 0);
    chk({tag, "_count_f"}, count_f, 0);
  endtask

  initial begin
    logic [7:0] d;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    chk_reset_vals("reset");

    // Fill with 0x01..0x10 and overflow once.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, 8'(i), 1'b0);
      if (i == 13) chk("af_at_13", almost_full, 0);
      if (i == 14) chk("af_at_14", almost_full, 1);
    end
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    cycle(1'b1, 1'b0, 8'hEE, 1'b0);
    chk("overflow_werr", wr_err, 1);
    chk("overflow_count", count, 16);

    // Drain in registered-read mode and underflow once.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_rdata", r_data, i);
    end
    chk("drain_empty", empty, 1);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    chk("underflow_rerr", rd_err, 1);
    chk("underflow_hold", r_data, 8'h10);

    // Full FIFO with simultaneous write/read: 0xAA comes out last.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'hAA, 1'b0);
    chk("simul_count", count, 16);
    chk("simul_werr", wr_err, 0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    chk("simul_last", r_data, 8'hAA);

    // Empty FIFO with simultaneous write/read: write wins, read errors.
    cycle(1'b1, 1'b1, 8'h5C, 1'b0);
    chk("esimul_rerr", rd_err, 1);
    chk("esimul_count", count, 1);
    chk("esimul_empty", empty, 0);
    chk("fwft_5c_a", r_data_f, 8'h5C);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h5C, 1'b0);
    chk("fwft_5c_b", r_data_f, 8'h5C);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Interleaved pairs walk the pointers around several times.
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      cycle(1'b1, 1'b0, d, 1'b0);
      chk("pair_fwft", r_data_f, d);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      chk("pair_rdata", r_data, d);
    end

    // Flush at count 5 with requests present.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0);
    chk("preflush_count", count, 5);
    cycle(1'b1, 1'b1, 8'h33, 1'b1);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_errs", {wr_err, rd_err}, 0);

    // Random traffic with a mid-burst asynchronous reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        q.delete();
        m_rdata = 8'h00; m_werr = 1'b0; m_rerr = 1'b0;
        repeat (3) cycle(1'b1, 1'b1, 8'h77, 1'b0);
        rst_n = 1'b1;
      end
      if ((i / 60) % 2 == 0)
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom),
              $urandom_range(0, 63) == 0);
      else
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
              $urandom_range(0, 63) == 0);
    end

    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
